// File: rtl/data_mem_responder.sv
// Word-addressed data memory with valid/ready request and response channels and fixed wait states.
// Optional out-of-range checking on the upper address bits is enabled by defining DATA_MEM_RANGE_CHECK_EN.
module data_mem_responder #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [31:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err
);

    if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait_cycles
        $error("data_mem_responder: WAIT_CYCLES=%0d is outside 0..15", WAIT_CYCLES);
    end

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t            state;
    logic [3:0]        wait_cnt;
    logic              write_q;
    logic              oob_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              addr_oob;
    logic              access;
    logic              mem_we;

    // Contents are not reset; simulation starts from an all-zero array.
    logic [DATA_W-1:0] mem [2**ADDR_W] = '{default: '0};

`ifdef DATA_MEM_RANGE_CHECK_EN
    assign addr_oob = |req_addr[31:ADDR_W];
`else
    logic unused_addr_hi;
    assign unused_addr_hi = |req_addr[31:ADDR_W];
    assign addr_oob       = 1'b0;
`endif

    assign access = (state == WAIT) && (wait_cnt == 4'd0);
    assign mem_we = access && write_q && !oob_q;

    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[addr_q] <= wdata_q;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            wait_cnt   <= 4'd0;
            write_q    <= 1'b0;
            oob_q      <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            req_ready  <= 1'b0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // Ready comes up one cycle after reset release or after a completed response.
                    if (req_valid && req_ready) begin
                        write_q   <= req_write;
                        oob_q     <= addr_oob;
                        addr_q    <= req_addr[ADDR_W-1:0];
                        wdata_q   <= req_wdata;
                        wait_cnt  <= WAIT_INIT;
                        req_ready <= 1'b0;
                        state     <= WAIT;
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        resp_valid <= 1'b1;
                        resp_err   <= oob_q;
                        resp_rdata <= (write_q || oob_q) ? '0 : mem[addr_q];
                        state      <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: table-driven transactions with a response scoreboard,
// plus hand-written reset, backpressure and zero-wait-state sequences.
module tb_data_mem_responder;

`ifdef DATA_MEM_RANGE_CHECK_EN
    localparam bit RANGE_CHECK = 1'b1;
`else
    localparam bit RANGE_CHECK = 1'b0;
`endif

    localparam int WAIT2 = 2;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          hold;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;

    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [31:0] resp_rdata;
    logic        resp_err;

    logic        req_valid_w0 = 1'b0;
    logic        req_ready_w0;
    logic        req_write_w0 = 1'b0;
    logic [31:0] req_addr_w0 = '0;
    logic [31:0] req_wdata_w0 = '0;
    logic        resp_valid_w0;
    logic        resp_ready_w0 = 1'b1;
    logic [31:0] resp_rdata_w0;
    logic        resp_err_w0;

    int   n_cmp = 0;
    int   n_fail = 0;
    int   cyc = 0;
    exp_t exp_q[$];
    vec_t vecs[9];

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    data_mem_responder #(.ADDR_W(8), .DATA_W(32), .WAIT_CYCLES(WAIT2)) u_dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    data_mem_responder #(.ADDR_W(8), .DATA_W(32), .WAIT_CYCLES(0)) u_dut_w0 (
        .clock      (clock),
        .reset_n    (reset_n),
        .req_valid  (req_valid_w0),
        .req_ready  (req_ready_w0),
        .req_write  (req_write_w0),
        .req_addr   (req_addr_w0),
        .req_wdata  (req_wdata_w0),
        .resp_valid (resp_valid_w0),
        .resp_ready (resp_ready_w0),
        .resp_rdata (resp_rdata_w0),
        .resp_err   (resp_err_w0)
    );

    task automatic compareVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Pops the expected response and checks it, including stability under backpressure and the handshake.
    task automatic checkOutput(input string name, input int hold);
        exp_t e;
        e = exp_q.pop_front();
        compareVal({name, " rdata"}, resp_rdata, e.rdata);
        compareVal({name, " err"}, 32'(resp_err), 32'(e.err));
        for (int i = 0; i < hold; i++) begin
            @(posedge clock);
            #1;
            compareVal({name, " held valid"}, 32'(resp_valid), 32'd1);
            compareVal({name, " held rdata"}, resp_rdata, e.rdata);
            compareVal({name, " held req_ready"}, 32'(req_ready), 32'd0);
        end
        if (hold > 0) begin
            @(negedge clock);
            resp_ready = 1'b1;
        end
        @(posedge clock);
        #1;
        compareVal({name, " valid after handshake"}, 32'(resp_valid), 32'd0);
        compareVal({name, " req_ready after handshake"}, 32'(req_ready), 32'd1);
    endtask

    task automatic applyStimulus(input vec_t v, input string name);
        int n;
        int lat;
        exp_t e;
        @(negedge clock);
        req_valid  = 1'b1;
        req_write  = v.wr;
        req_addr   = v.addr;
        req_wdata  = v.wdata;
        resp_ready = (v.hold == 0);
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (!req_ready) begin
            compareVal({name, " accept timeout"}, 32'(req_ready), 32'd1);
            req_valid = 1'b0;
            return;
        end
        @(posedge clock);
        e.rdata = v.exp_rdata;
        e.err   = v.exp_err;
        exp_q.push_back(e);
        #1;
        // Scrambled inputs while busy must not affect the transaction in flight.
        req_valid = 1'b0;
        req_write = ~v.wr;
        req_addr  = ~v.addr;
        req_wdata = ~v.wdata;
        lat = 0;
        while (!resp_valid && lat < 50) begin
            @(posedge clock);
            #1;
            lat++;
        end
        compareVal({name, " latency"}, 32'(lat), 32'(WAIT2 + 1));
        if (!resp_valid) begin
            void'(exp_q.pop_front());
            return;
        end
        checkOutput(name, v.hold);
    endtask

    task automatic xactW0(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rdata, input string name, output int acc_cyc);
        int n;
        exp_t e;
        acc_cyc = -1;
        @(negedge clock);
        req_valid_w0 = 1'b1;
        req_write_w0 = wr;
        req_addr_w0  = addr;
        req_wdata_w0 = wdata;
        n = 0;
        while (!req_ready_w0 && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (!req_ready_w0) begin
            compareVal({name, " accept timeout"}, 32'(req_ready_w0), 32'd1);
            req_valid_w0 = 1'b0;
            return;
        end
        @(posedge clock);
        e.rdata = exp_rdata;
        e.err   = 1'b0;
        exp_q.push_back(e);
        #1;
        acc_cyc = cyc;
        req_valid_w0 = 1'b0;
        @(posedge clock);
        #1;
        compareVal({name, " valid 1 edge after accept"}, 32'(resp_valid_w0), 32'd1);
        e = exp_q.pop_front();
        compareVal({name, " rdata"}, resp_rdata_w0, e.rdata);
        compareVal({name, " err"}, 32'(resp_err_w0), 32'(e.err));
        @(posedge clock);
        #1;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int t0;
        int t1;
        vec_t v;

        vecs[0] = '{1'b1, 32'd5,     32'hDEADBEEF, 32'h0,        1'b0,        0};
        vecs[1] = '{1'b0, 32'd5,     32'h0,        32'hDEADBEEF, 1'b0,        0};
        vecs[2] = '{1'b0, 32'd5,     32'h0,        32'hDEADBEEF, 1'b0,        4};
        vecs[3] = '{1'b1, 32'h100,   32'hA5A5A5A5, 32'h0,        RANGE_CHECK, 0};
        vecs[4] = '{1'b0, 32'd0,     32'h0,        RANGE_CHECK ? 32'h0 : 32'hA5A5A5A5, 1'b0, 0};
        vecs[5] = '{1'b1, 32'd255,   32'hCAFEF00D, 32'h0,        1'b0,        0};
        vecs[6] = '{1'b0, 32'd255,   32'h0,        32'hCAFEF00D, 1'b0,        0};
        vecs[7] = '{1'b0, 32'h1FF,   32'h0,        RANGE_CHECK ? 32'h0 : 32'hCAFEF00D, RANGE_CHECK, 0};
        vecs[8] = '{1'b0, 32'd6,     32'h0,        32'h0,        1'b0,        0};

        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            compareVal("reset req_ready", 32'(req_ready), 32'd0);
            compareVal("reset resp_valid", 32'(resp_valid), 32'd0);
            compareVal("reset resp_err", 32'(resp_err), 32'd0);
        end
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        compareVal("req_ready after release", 32'(req_ready), 32'd1);
        compareVal("resp_valid after release", 32'(resp_valid), 32'd0);

        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset during the wait states discards the pending store.
        @(negedge clock);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 32'd9;
        req_wdata = 32'h12345678;
        resp_ready = 1'b1;
        for (int n = 0; n < 50 && !req_ready; n++) @(negedge clock);
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        compareVal("mid-reset req_ready", 32'(req_ready), 32'd0);
        compareVal("mid-reset resp_valid", 32'(resp_valid), 32'd0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        v = '{1'b0, 32'd9, 32'h0, 32'h0, 1'b0, 0};
        applyStimulus(v, "load after mid-reset");
        v = '{1'b0, 32'd5, 32'h0, 32'hDEADBEEF, 1'b0, 0};
        applyStimulus(v, "committed store survives reset");

        xactW0(1'b1, 32'd0, 32'h00000011, 32'h0, "w0 store0", t0);
        xactW0(1'b1, 32'd1, 32'h00000022, 32'h0, "w0 store1", t0);
        xactW0(1'b0, 32'd0, 32'h0, 32'h00000011, "w0 load0", t0);
        xactW0(1'b0, 32'd1, 32'h0, 32'h00000022, "w0 load1", t1);
        compareVal("w0 accept spacing", 32'(t1 - t0), 32'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Word-addressed data-memory responder that serves load/store requests from the processor core over a valid/ready request channel and a valid/ready response channel. It is the memory-side end of the core's data-memory port and replaces the zero-latency combinational memory when the core is built multi-cycle. It inserts a fixed number of wait states per access, so the core's handshake logic is exercised under realistic latency.

## Interface
Parameters:
- ADDR_W, 8, log2 of the memory depth in 32-bit words (depth = 2^ADDR_W)
- DATA_W, 32, word width
- WAIT_CYCLES, 2, wait states inserted between request acceptance and the array access (0..15)

Ports:
- clock  in  1  single clock, all state changes on its rising edge
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  responder can accept a request
- req_write  in  1  1 = store, 0 = load
- req_addr  in  32  word address (not byte address)
- req_wdata  in  DATA_W  store data
- resp_valid  out  1  response present
- resp_ready  in  1  core accepts the response
- resp_rdata  out  DATA_W  load data; 0 for stores and errors
- resp_err  out  1  address out of range (see Configuration)

## Operation
- FSM states: IDLE, WAIT, RESP. Reset enters IDLE.
- IDLE: req_ready=1. On req_valid&req_ready, latch req_write, req_addr and req_wdata. Load the wait counter with WAIT_CYCLES and go to WAIT; if WAIT_CYCLES=0, go directly to the access edge (see Timing).
- WAIT: req_ready=0. Decrement the counter each cycle. When the counter reaches 0, perform the access and go to RESP.
- Access:
  - Load: resp_rdata <= mem[addr[ADDR_W-1:0]].
  - Store: mem[addr[ADDR_W-1:0]] <= wdata and resp_rdata <= 0.
- RESP: resp_valid=1 and req_ready=0. resp_rdata and resp_err are held stable until resp_valid&resp_ready; the FSM then returns to IDLE.
- Only one request is outstanding at a time. No request is accepted in the cycle the response completes.
- Request inputs are sampled only on the accept edge; changes while the FSM is busy are ignored.
- The array is not reset. It is initialised to all zeros at time 0 for simulation.
- Reset outputs: req_ready=0 while reset_n=0, and 1 on the first cycle after release. resp_valid=0, resp_rdata=0, resp_err=0.

## Timing
- Accept edge = E0. The access happens on edge E0+WAIT_CYCLES+1, and resp_valid rises in the same cycle as that edge's output.
- Minimum request-to-request spacing is WAIT_CYCLES+3 cycles, given the accept cycle, the wait states, the access edge, the RESP cycle and the return to IDLE.
- A store is visible to a load accepted after that store's response handshake; there is no read-during-write hazard.
- Reset asserted mid-operation: the FSM goes to IDLE immediately and all outputs go to their reset values.
  - A store whose access edge has not yet occurred is discarded and memory is unchanged.
  - A store already committed stays committed.
- Address wrap: without range checking, addr bits above ADDR_W-1 are ignored, so word 2^ADDR_W aliases word 0.
- The wait counter is 4 bits wide. WAIT_CYCLES outside 0..15 is illegal and gets a simulation-time $error.

## Configuration
- Macro: DATA_MEM_RANGE_CHECK_EN.
- Defined: if any bit of req_addr[31:ADDR_W] is set, the request is still fully handshaken with the same latency, but:
  - a store does not write the array;
  - the response carries resp_err=1 and resp_rdata=0.
- Undefined: resp_err is tied to 0 and addresses wrap modulo 2^ADDR_W.

## Test plan
- Reset: hold reset_n=0 for 3 cycles, then release -> resp_valid=0 and resp_err=0 throughout; req_ready=0 during reset and 1 on the first cycle after release.
- Store then load, WAIT_CYCLES=2:
  - store 0xDEADBEEF to addr 5 -> resp_valid exactly 3 edges after accept, with resp_rdata=0;
  - load addr 5 -> resp_rdata=0xDEADBEEF.
- Response backpressure: hold resp_ready=0 for 4 cycles during a load of addr 5 -> resp_valid and resp_rdata remain stable and req_ready=0; accepted on the first resp_ready=1 cycle, with req_ready=1 on the next cycle.
- WAIT_CYCLES=0: back-to-back loads of addr 0 and addr 1 with resp_ready=1 -> each response arrives 1 edge after its accept, and accepts are 3 cycles apart.
- Reset mid-access: accept a store of 0x12345678 to addr 9, then assert reset_n=0 during WAIT -> a subsequent load of addr 9 returns 0.
- Out-of-range address 0x100 (ADDR_W=8), store 0xA5A5A5A5:
  - with DATA_MEM_RANGE_CHECK_EN -> resp_err=1, and a later load of addr 0 returns 0;
  - without it -> resp_err=0, and a load of addr 0 returns 0xA5A5A5A5.
